inst_fetch_queue: RTL and testbench

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

---
 rtl/inst_fetch_queue.sv | 148 ++++++++++++++
 tb/tb_inst_fetch_queue.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: one outstanding memory fetch feeding a
// small FIFO toward decode. Optional macro: FETCH_QUEUE_BYPASS_EN.
module inst_fetch_queue #(
  parameter int DATA_SIZE = 32,
  parameter int DEPTH = 4,
  parameter logic [DATA_SIZE-1:0] RESET_PC = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [DATA_SIZE-1:0]   redirect_pc,
  output logic                   mem_req_valid,
  output logic [DATA_SIZE-1:0]   mem_req_addr,
  input  logic                   mem_req_ready,
  input  logic                   mem_rsp_valid,
  input  logic [31:0]            mem_rsp_inst,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_SIZE-1:0]   out_pc,
  output logic [DATA_SIZE-1:0]   out_pc_plus_4,
  output logic [31:0]            out_inst,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [DATA_SIZE-1:0] FOUR = DATA_SIZE'(4);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [DATA_SIZE-1:0] fetch_pc;
  logic [DATA_SIZE-1:0] req_pc;
  logic [DATA_SIZE-1:0] req_pc4;
  logic [DATA_SIZE-1:0] redirect_al;
  logic [PW-1:0]        head;
  logic [PW-1:0]        tail;
  logic [CW-1:0]        cnt_q;

  logic [DATA_SIZE-1:0] pc_q   [DEPTH];
  logic [DATA_SIZE-1:0] pc4_q  [DEPTH];
  logic [31:0]          inst_q [DEPTH];

  logic full;
  logic empty;
  logic rsp_take;
  logic req_fire;
  logic byp;
  logic push;
  logic pop;

  assign full        = (cnt_q == CW'(DEPTH));
  assign empty       = (cnt_q == '0);
  assign rsp_take    = (state == WAIT) & mem_rsp_valid & ~flush;
  assign req_fire    = mem_req_valid & mem_req_ready;
  assign req_pc4     = req_pc + FOUR;
  assign redirect_al = redirect_pc & ~DATA_SIZE'(3);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = empty & rsp_take;
`else
  assign byp = 1'b0;
`endif

  assign push = rsp_take & ~(byp & out_ready);
  assign pop  = ~empty & out_ready & ~flush;

  assign out_valid     = ~empty | byp;
  assign out_pc        = byp ? req_pc       : pc_q[head];
  assign out_pc_plus_4 = byp ? req_pc4      : pc4_q[head];
  assign out_inst      = byp ? mem_rsp_inst : inst_q[head];
  assign mem_req_addr  = fetch_pc;
  assign count         = cnt_q;

  // Fetch FSM: next state and memory request.
  always_comb begin
    state_nx      = state;
    mem_req_valid = 1'b0;
    unique case (state)
      IDLE: begin
        mem_req_valid = ~reset & ~flush & ~full;
        if (mem_req_valid && mem_req_ready)
          state_nx = WAIT;
      end
      WAIT: begin
        if (mem_rsp_valid)
          state_nx = IDLE;
        else if (flush)
          state_nx = DROP;
      end
      DROP: begin
        if (mem_rsp_valid)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, fetch PC and queue pointers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      head     <= '0;
      tail     <= '0;
      cnt_q    <= '0;
    end else begin
      state <= state_nx;
      if (flush)
        fetch_pc <= redirect_al;
      else if (req_fire)
        fetch_pc <= fetch_pc + FOUR;
      if (req_fire)
        req_pc <= fetch_pc;
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        cnt_q <= '0;
      end else begin
        if (push)
          tail <= tail + PW'(1);
        if (pop)
          head <= head + PW'(1);
        if (push && !pop)
          cnt_q <= cnt_q + CW'(1);
        else if (pop && !push)
          cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  // Queue storage written at the tail.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_q[tail]   <= req_pc;
      pc4_q[tail]  <= req_pc4;
      inst_q[tail] <= mem_rsp_inst;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue (DEPTH=4, RESET_PC=0x100).
// Memory model answers with inst = {addr[15:0], 16'hC0DE}.
module tb_inst_fetch_queue;

  logic        clock;
  logic        reset;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus_4;
  logic [31:0] out_inst;
  logic [2:0]  count;

  inst_fetch_queue #(
    .DATA_SIZE(32),
    .DEPTH(4),
    .RESET_PC(32'h100)
  ) dut (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid),
    .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_inst(mem_rsp_inst),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_pc_plus_4(out_pc_plus_4),
    .out_inst(out_inst),
    .count(count)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;
  int rsp_delay = 1;
  int rcnt = 0;
  logic [31:0] paddr = '0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic expect_e(input logic [31:0] pc, input logic [31:0] pc4,
                          input logic [31:0] inst);
    exp_t e;
    e.pc = pc;
    e.pc4 = pc4;
    e.inst = inst;
    sb.push_back(e);
  endtask

  task automatic wait_acc(input int target);
    bit ok;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clock);
      #2;
      if (n_acc >= target) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("wait_accept_timeout", 64'(n_acc), 64'(target));
  endtask

  task automatic wait_count(input int target);
    bit ok;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clock);
      #3;
      if (count == 3'(target)) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("wait_count_timeout", 64'(count), 64'(target));
  endtask

  // Memory model: accepts when ready, answers rsp_delay cycles later.
  initial begin
    mem_rsp_valid = 1'b0;
    mem_rsp_inst = '0;
    forever begin
      bit hs;
      logic [31:0] a;
      @(negedge clock);
      hs = mem_req_valid && mem_req_ready;
      a = mem_req_addr;
      @(posedge clock);
      #1;
      mem_rsp_valid = 1'b0;
      if (hs) begin
        n_acc++;
        paddr = a;
        rcnt = rsp_delay;
      end
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_inst = {paddr[15:0], 16'hC0DE};
        end
      end
    end
  end

  // Monitor: every entry consumed by decode is checked in order.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got pc %h expected none", out_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_pc", 64'(out_pc), 64'(e.pc));
        chk("out_pc_plus_4", 64'(out_pc_plus_4), 64'(e.pc4));
        chk("out_inst", 64'(out_inst), 64'(e.inst));
      end
    end
  end

  initial begin
    int base;
    reset = 1'b1;
    flush = 1'b0;
    redirect_pc = '0;
    mem_req_ready = 1'b1;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clock);
    #3;
    chk("rst_req_valid", 64'(mem_req_valid), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_count", 64'(count), 0);

    // Streaming fetch from RESET_PC
    expect_e(32'h100, 32'h104, 32'h0100C0DE);
    expect_e(32'h104, 32'h108, 32'h0104C0DE);
    expect_e(32'h108, 32'h10C, 32'h0108C0DE);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #2;
    chk("first_req_valid", 64'(mem_req_valid), 1);
    chk("first_req_addr", 64'(mem_req_addr), 64'h100);
    wait_acc(1);
    #1;
    chk("rsp_cycle_count", 64'(count), 0);
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("bypass_out_valid", 64'(out_valid), 1);
    @(posedge clock);
    #3;
    chk("bypass_count_next", 64'(count), 0);
    chk("bypass_valid_next", 64'(out_valid), 0);
`else
    chk("nobyp_out_valid", 64'(out_valid), 0);
    @(posedge clock);
    #3;
    chk("nobyp_count_next", 64'(count), 1);
    chk("nobyp_valid_next", 64'(out_valid), 1);
`endif
    wait_acc(3);
    mem_req_ready = 1'b0;
    repeat (5) @(posedge clock);
    #3;
    chk("stream_drained", 64'(count), 0);

    // Backpressure fills the queue
    expect_e(32'h10C, 32'h110, 32'h010CC0DE);
    expect_e(32'h110, 32'h114, 32'h0110C0DE);
    expect_e(32'h114, 32'h118, 32'h0114C0DE);
    expect_e(32'h118, 32'h11C, 32'h0118C0DE);
    expect_e(32'h11C, 32'h120, 32'h011CC0DE);
    out_ready = 1'b0;
    mem_req_ready = 1'b1;
    wait_count(4);
    repeat (2) @(posedge clock);
    #3;
    chk("full_req_valid", 64'(mem_req_valid), 0);
    chk("full_count", 64'(count), 4);
    base = n_acc;
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    #2;
    chk("pulse_req_valid", 64'(mem_req_valid), 0);
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    #2;
    chk("pulse_count", 64'(count), 3);
    chk("pulse_next_req", 64'(mem_req_valid), 1);
    chk("pulse_next_addr", 64'(mem_req_addr), 64'h11C);
    repeat (4) @(posedge clock);
    #3;
    chk("refill_count", 64'(count), 4);
    chk("refill_one_req", 64'(n_acc - base), 1);
    @(posedge clock);
    #1;
    mem_req_ready = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clock);
    #3;
    chk("fill_drained", 64'(count), 0);

    // Flush while waiting; late response dropped
    expect_e(32'h200, 32'h204, 32'h0200C0DE);
    rsp_delay = 3;
    @(posedge clock);
    #1;
    mem_req_ready = 1'b1;
    wait_acc(n_acc + 1);
    flush = 1'b1;
    redirect_pc = 32'h203;
    rsp_delay = 1;
    #1;
    chk("wflush_req_valid", 64'(mem_req_valid), 0);
    @(posedge clock);
    #1;
    flush = 1'b0;
    #2;
    chk("drop_req_valid", 64'(mem_req_valid), 0);
    chk("drop_count", 64'(count), 0);
    @(posedge clock);
    #3;
    chk("drop_rsp_req_valid", 64'(mem_req_valid), 0);
    chk("drop_rsp_count", 64'(count), 0);
    @(posedge clock);
    #3;
    chk("redir_req_valid", 64'(mem_req_valid), 1);
    chk("redir_addr", 64'(mem_req_addr), 64'h200);
    @(posedge clock);
    #1;
    mem_req_ready = 1'b0;
    repeat (4) @(posedge clock);
    #3;
    chk("redir_drained", 64'(count), 0);

    // Flush coincident with response
    expect_e(32'h300, 32'h304, 32'h0300C0DE);
    @(posedge clock);
    #1;
    mem_req_ready = 1'b1;
    wait_acc(n_acc + 1);
    flush = 1'b1;
    redirect_pc = 32'h300;
    #1;
    chk("cflush_out_valid", 64'(out_valid), 0);
    @(posedge clock);
    #1;
    flush = 1'b0;
    #2;
    chk("cflush_count", 64'(count), 0);
    chk("cflush_out_valid2", 64'(out_valid), 0);
    chk("cflush_req_valid", 64'(mem_req_valid), 1);
    chk("cflush_addr", 64'(mem_req_addr), 64'h300);
    @(posedge clock);
    #1;
    mem_req_ready = 1'b0;
    repeat (4) @(posedge clock);
    #3;
    chk("cflush_drained", 64'(count), 0);

    // Address wrap at top of address space
    expect_e(32'hFFFFFFFC, 32'h0, 32'hFFFCC0DE);
    expect_e(32'h0, 32'h4, 32'h0000C0DE);
    @(posedge clock);
    #1;
    flush = 1'b1;
    redirect_pc = 32'hFFFFFFFC;
    @(posedge clock);
    #1;
    flush = 1'b0;
    mem_req_ready = 1'b1;
    wait_acc(n_acc + 2);
    mem_req_ready = 1'b0;
    repeat (5) @(posedge clock);
    #3;
    chk("wrap_drained", 64'(count), 0);
    chk("wrap_next_addr", 64'(mem_req_addr), 64'h4);

    // Reset while a request is outstanding
    rsp_delay = 2;
    @(posedge clock);
    #1;
    mem_req_ready = 1'b1;
    wait_acc(n_acc + 1);
    reset = 1'b1;
    mem_req_ready = 1'b0;
    #1;
    chk("mrst_req_valid", 64'(mem_req_valid), 0);
    chk("mrst_out_valid", 64'(out_valid), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #2;
    chk("mrst_addr", 64'(mem_req_addr), 64'h100);
    chk("mrst_req_after", 64'(mem_req_valid), 1);
    repeat (3) @(posedge clock);
    #3;
    chk("mrst_rsp_ignored", 64'(count), 0);
    chk("mrst_no_out", 64'(out_valid), 0);

    chk("sb_empty", 64'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
